// File: rtl/lbp_pkg.sv
// Shared constants, FSM state type and pixel addressing helper for the LBP host.
// Optional written-flag coverage is enabled by defining LBP_HOST_COVER_EN.
package lbp_pkg;

    localparam int WIDTH  = 128;
    localparam int DATA_W = 8;
    localparam int ROW_W  = $clog2(WIDTH);
    localparam int ADDR_W = 2 * ROW_W;
    localparam int NPIX   = WIDTH * WIDTH;

    typedef enum logic [1:0] {
        LOAD,
        SERVE,
        DRAIN,
        DONE
    } lbp_host_state_t;

    // Raster address of a pixel: row in the upper half, column in the lower half.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                   input logic [ROW_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/lbp_host_ram.sv
// Simple storage array: one synchronous write port, one asynchronous read port.
// Used for both the gray image and the LBP result memories of lbp_host.
module lbp_host_ram #(
    parameter int DEPTH = 16384,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; every location is written before it is meaningfully read,
    // and a reset network on a RAM array would block mapping onto memory macros.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lbp_host.sv
// Responder side of the LBP engine interface: loads a gray image, serves zero-latency
// reads, captures results and drains them in raster order. Coverage: LBP_HOST_COVER_EN.
module lbp_host
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   wr_cnt,
    output logic [ADDR_W:0]   cov_miss,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(NPIX);

    lbp_host_state_t   state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;
    logic              gray_ready_q;
    logic              done_q;
    logic              load_ready_q;

    logic              in_load, in_serve, in_drain;
    logic              load_fire, lbp_fire, rd_fire, serve_entry;
    logic [DATA_W-1:0] gray_rdata, lbp_rdata;

    assign in_load     = (state_q == LOAD);
    assign in_serve    = (state_q == SERVE);
    assign in_drain    = (state_q == DRAIN);
    assign load_fire   = in_load  & load_valid;
    assign lbp_fire    = in_serve & lbp_valid;
    assign rd_fire     = in_drain & rd_ready;
    assign serve_entry = load_fire & (load_ptr_q == LAST_ADDR);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves it
        // unassigned and no latch is inferred.
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_cnt_d   = wr_cnt_q;

        unique case (state_q)
            LOAD: begin
                if (load_fire) begin
                    load_ptr_d = load_ptr_q + 1'b1;
                    if (load_ptr_q == LAST_ADDR) begin
                        state_d    = SERVE;
                        load_ptr_d = '0;
                        wr_cnt_d   = '0;
                    end
                end
            end
            SERVE: begin
                // A result write coincident with finish is still counted before leaving.
                if (lbp_fire && (wr_cnt_q != FULL_CNT)) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
                if (finish) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_fire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d    = LOAD;
                load_ptr_d = '0;
                rd_ptr_d   = '0;
            end
            default: state_d = LOAD;
        endcase
    end

    assign err_d = err_q
                 | (~in_serve & (lbp_valid | gray_req | finish))
                 | (~in_load  & load_valid);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD;
            load_ptr_q   <= '0;
            rd_ptr_q     <= '0;
            wr_cnt_q     <= '0;
            err_q        <= 1'b0;
            gray_ready_q <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_cnt_q     <= wr_cnt_d;
            err_q        <= err_d;
            gray_ready_q <= serve_entry;
            done_q       <= (state_d == DONE);
            load_ready_q <= (state_d == LOAD);
        end
    end

`ifdef LBP_HOST_COVER_EN
    logic [NPIX-1:0]  flag_q;
    logic [ADDR_W:0]  cov_miss_q;

    // Flags need no reset: they are always cleared on entry to SERVE before use.
    always_ff @(posedge clk) begin
        if (serve_entry) begin
            flag_q <= '0;
        end else if (lbp_fire) begin
            flag_q[lbp_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cov_miss_q <= '0;
        end else if (serve_entry) begin
            cov_miss_q <= '0;
        end else if (rd_fire && !flag_q[rd_ptr_q]) begin
            cov_miss_q <= cov_miss_q + 1'b1;
        end
    end

    assign cov_miss = cov_miss_q;
`else
    assign cov_miss = '0;
`endif

    lbp_host_ram #(
        .DEPTH (NPIX),
        .DW    (DATA_W),
        .AW    (ADDR_W)
    ) gray_mem (
        .clk     (clk),
        .we_i    (load_fire),
        .waddr_i (load_ptr_q),
        .wdata_i (load_data),
        .raddr_i (gray_addr),
        .rdata_o (gray_rdata)
    );

    lbp_host_ram #(
        .DEPTH (NPIX),
        .DW    (DATA_W),
        .AW    (ADDR_W)
    ) lbp_mem (
        .clk     (clk),
        .we_i    (lbp_fire),
        .waddr_i (lbp_addr),
        .wdata_i (lbp_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (lbp_rdata)
    );

    assign load_ready = load_ready_q;
    assign gray_ready = gray_ready_q;
    assign gray_data  = gray_req ? gray_rdata : '0;
    assign rd_valid   = in_drain;
    assign rd_data    = in_drain ? lbp_rdata : '0;
    assign wr_cnt     = wr_cnt_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lbp_host.sv
// Directed self-checking bench for lbp_host: ramp/flat image loads, result capture,
// stalled drain, protocol error and mid-DRAIN reset. Honours LBP_HOST_COVER_EN.
module tb_lbp_host;
    import lbp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [DATA_W-1:0] lbp_data;
    logic              finish;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   cov_miss;
    logic              done;
    logic              err;

    int n_checks   = 0;
    int n_errors   = 0;
    int done_seen  = 0;

    always #5 clk = ~clk;

    lbp_host dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .wr_cnt     (wr_cnt),
        .cov_miss   (cov_miss),
        .done       (done),
        .err        (err)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load_ready(input string tag);
        int k = 0;
        while (load_ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check(tag, 32'(load_ready), 32'd1);
    endtask

    function automatic bit is_border(input int a);
        int row = a / WIDTH;
        int col = a % WIDTH;
        return (row == 0) || (row == WIDTH - 1) || (col == 0) || (col == WIDTH - 1);
    endfunction

    // Frame A result image: border 0x00, interior 0xFF, addr 200 overwritten with 0xA5.
    function automatic logic [7:0] exp_a(input int a);
        if (a == 200) return 8'hA5;
        return is_border(a) ? 8'h00 : 8'hFF;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd0);
        check({tag, "_gray_ready"}, 32'(gray_ready), 32'd0);
        check({tag, "_gray_data"},  32'(gray_data),  32'd0);
        check({tag, "_rd_valid"},   32'(rd_valid),   32'd0);
        check({tag, "_rd_data"},    32'(rd_data),    32'd0);
        check({tag, "_wr_cnt"},     32'(wr_cnt),     32'd0);
        check({tag, "_cov_miss"},   32'(cov_miss),   32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        gray_req   = 1'b0;
        gray_addr  = '0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        rd_ready   = 1'b0;

        #1;
        check_all_zero("reset");
        step();
        step();
        reset = 1'b1;
        wait_load_ready("load_ready_after_reset");

        // Frame A: ramp image.
        load_valid = 1'b1;
        for (int a = 0; a < NPIX; a++) begin
            load_data = 8'(a);
            step();
        end
        load_valid = 1'b0;
        check("gray_ready_first", 32'(gray_ready), 32'd1);
        check("load_ready_serve", 32'(load_ready), 32'd0);
        step();
        check("gray_ready_once", 32'(gray_ready), 32'd0);

        gray_req  = 1'b1;
        gray_addr = pix_addr(7'd1, 7'd1);
        #1 check("gray_129", 32'(gray_data), 32'h81);
        gray_addr = ADDR_W'(300);
        #1 check("gray_300", 32'(gray_data), 32'h2C);
        gray_addr = ADDR_W'(NPIX - 1);
        #1 check("gray_last", 32'(gray_data), 32'hFF);
        gray_req  = 1'b0;
        #1 check("gray_idle_zero", 32'(gray_data), 32'h00);

        // Full result frame, then a rewrite of addr 200 coincident with finish.
        lbp_valid = 1'b1;
        for (int a = 0; a < NPIX; a++) begin
            lbp_addr = ADDR_W'(a);
            lbp_data = is_border(a) ? 8'h00 : 8'hFF;
            step();
            if (a == 99) check("wr_cnt_100", 32'(wr_cnt), 32'd100);
        end
        lbp_addr = ADDR_W'(200);
        lbp_data = 8'hA5;
        finish   = 1'b1;
        step();
        lbp_valid = 1'b0;
        finish    = 1'b0;
        check("wr_cnt_saturated", 32'(wr_cnt), 32'(NPIX));
        check("rd_valid_drain", 32'(rd_valid), 32'd1);
        check("err_clean_a", 32'(err), 32'd0);

        // Drain with a 5-cycle stall at beat 300.
        rd_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            if (i == 300) begin
                rd_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check("rd_stall_hold", 32'(rd_data), 32'(exp_a(300)));
                    step();
                end
                rd_ready = 1'b1;
            end
            check("rd_data_a", 32'(rd_data), 32'(exp_a(i)));
            step();
        end
        rd_ready = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("rd_valid_done", 32'(rd_valid), 32'd0);
        step();
        check("done_low", 32'(done), 32'd0);
        check("load_ready_again", 32'(load_ready), 32'd1);
        check("done_seen_once", 32'(done_seen), 32'd1);

        // Illegal result write during LOAD: flags err and must not touch lbp_mem[5].
        lbp_valid = 1'b1;
        lbp_addr  = ADDR_W'(5);
        lbp_data  = 8'h77;
        step();
        lbp_valid = 1'b0;
        check("err_set", 32'(err), 32'd1);

        // Frame B: flat 0x55 image, interior-only results.
        load_valid = 1'b1;
        load_data  = 8'h55;
        for (int a = 0; a < NPIX; a++) step();
        load_valid = 1'b0;
        check("gray_ready_b", 32'(gray_ready), 32'd1);
        gray_req  = 1'b1;
        gray_addr = pix_addr(7'd1, 7'd1);
        #1 check("gray_b_129", 32'(gray_data), 32'h55);
        gray_req  = 1'b0;

        lbp_data = 8'hFF;
        for (int a = 0; a < NPIX; a++) begin
            if (!is_border(a)) begin
                lbp_valid = 1'b1;
                lbp_addr  = ADDR_W'(a);
                step();
            end
        end
        lbp_valid = 1'b0;
        finish    = 1'b1;
        step();
        finish    = 1'b0;
        check("wr_cnt_interior", 32'(wr_cnt), 32'd15876);
        check("err_sticky", 32'(err), 32'd1);

        // Partial drain: border keeps frame A's 0x00 (addr 5 never became 0x77).
        rd_ready = 1'b1;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            check("rd_data_b", 32'(rd_data), is_border(i) ? 32'h00 : 32'hFF);
            step();
        end
        rd_ready = 1'b0;
`ifdef LBP_HOST_COVER_EN
        check("cov_miss_partial", 32'(cov_miss), 32'd130);
`else
        check("cov_miss_off", 32'(cov_miss), 32'd0);
`endif
        check("err_still_set", 32'(err), 32'd1);

        // Asynchronous reset mid-DRAIN.
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        step();
        reset = 1'b1;
        wait_load_ready("load_ready_post_reset");
        check("err_cleared", 32'(err), 32'd0);
        check("rd_valid_post_reset", 32'(rd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
